// File: rtl/exe_wb_stage_pkg.sv
// Shared definitions for the execute/writeback stage: widths, AluControl bit
// positions, FSM encoding and the one-hot priority helper.
package exe_wb_stage_pkg;

  localparam int unsigned DW      = 19;
  localparam int unsigned AW      = 8;
  localparam int unsigned NUM_OPS = 20;

  localparam int unsigned ADD_B  = 19;
  localparam int unsigned SUB_B  = 18;
  localparam int unsigned MUL_B  = 17;
  localparam int unsigned DIV_B  = 16;
  localparam int unsigned INC_B  = 15;
  localparam int unsigned DEC_B  = 14;
  localparam int unsigned AND_B  = 13;
  localparam int unsigned OR_B   = 12;
  localparam int unsigned XOR_B  = 11;
  localparam int unsigned NOT_B  = 10;
  localparam int unsigned JUMP_B = 9;
  localparam int unsigned BEQ_B  = 8;
  localparam int unsigned BNE_B  = 7;
  localparam int unsigned CALL_B = 6;
  localparam int unsigned RET_B  = 5;
  localparam int unsigned LD_B   = 4;
  localparam int unsigned ST_B   = 3;
  localparam int unsigned ENC_B  = 2;
  localparam int unsigned DENC_B = 1;
  localparam int unsigned FFT_B  = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMulRun = 2'd1,
    StDivRun = 2'd2
  } state_e;

  // Keep only the highest set bit so a malformed control word still decodes one-hot.
  function automatic logic [NUM_OPS-1:0] highest_onehot(input logic [NUM_OPS-1:0] ctl);
    logic [NUM_OPS-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (ctl[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/exe_wb_stage_data_mem.sv
// Data memory: synchronous write, combinational read, contents not reset.
module exe_wb_stage_data_mem #(
  parameter int unsigned DW = 19,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/exe_wb_stage.sv
// Execute/writeback stage: single-cycle ALU and memory ops, iterative 19-step
// MUL/DIV that stalls upstream, registered writeback triple.
module exe_wb_stage #(
  parameter int unsigned   DW      = exe_wb_stage_pkg::DW,
  parameter int unsigned   AW      = exe_wb_stage_pkg::AW,
  parameter logic [DW-1:0] ENC_KEY = 19'h2D2D5
) (
  input  logic          clk,
  input  logic          RegRst,
  input  logic          RegWriteE,
  input  logic          memtoRegE,
  input  logic          memwriteE,
  input  logic [19:0]   AluControlE,
  input  logic          AluSrcE,
  input  logic [DW-1:0] RD1_2_dataE,
  input  logic [DW-1:0] RD3_dataE,
  input  logic [AW-1:0] addrE,
  input  logic [1:0]    r1E_addr,
  output logic          RegWriteW,
  output logic [1:0]    a3W,
  output logic [DW-1:0] wd3,
  output logic          stallE,
  output logic          div0_flag
);
  import exe_wb_stage_pkg::*;

  localparam int unsigned CW = $clog2(DW);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;    // MUL partial product / DIV quotient
  logic [DW:0]   rem_q, rem_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]    dst_q, dst_d;
  logic          we_q, we_d;
  logic          reg_write_d, div0_d;
  logic [1:0]    a3_d;
  logic [DW-1:0] wd3_d;

  logic [NUM_OPS-1:0] sel;
  logic [DW-1:0]      op_a, op_b, mem_rdata, alu_res, enc_rot, denc_x, mul_step, quo_sh;
  logic [DW:0]        rem_sh, rem_sub;

  assign sel     = highest_onehot(AluControlE);
  assign op_a    = RD1_2_dataE;
  assign op_b    = AluSrcE ? {{(DW-AW){1'b0}}, addrE} : RD3_dataE;
  assign enc_rot = {op_a[DW-4:0], op_a[DW-1:DW-3]};
  assign denc_x  = op_a ^ ENC_KEY;
  assign stallE  = (state_q != StIdle);

  exe_wb_stage_data_mem #(
    .DW(DW),
    .AW(AW)
  ) u_data_mem (
    .clk  (clk),
    .we   (memwriteE && (state_q == StIdle)),
    .addr (addrE),
    .wdata(RD1_2_dataE),
    .rdata(mem_rdata)
  );

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      sel[ADD_B]:  alu_res = op_a + op_b;
      sel[SUB_B]:  alu_res = op_a - op_b;
      sel[INC_B]:  alu_res = op_a + DW'(1);
      sel[DEC_B]:  alu_res = op_a - DW'(1);
      sel[AND_B]:  alu_res = op_a & op_b;
      sel[OR_B]:   alu_res = op_a | op_b;
      sel[XOR_B]:  alu_res = op_a ^ op_b;
      sel[NOT_B]:  alu_res = ~op_a;
      sel[ENC_B]:  alu_res = enc_rot ^ ENC_KEY;
      sel[DENC_B]: alu_res = {denc_x[2:0], denc_x[DW-1:3]};
      default:     alu_res = '0;
    endcase
    if (sel[LD_B] || memtoRegE) alu_res = mem_rdata;
  end

  // MUL walks the multiplier MSB-first; DIV is a restoring shift-subtract.
  always_comb begin
    mul_step = {acc_q[DW-2:0], 1'b0} + (opb_q[cnt_q] ? opa_q : '0);
    rem_sh   = {rem_q[DW-1:0], acc_q[DW-1]};
    quo_sh   = {acc_q[DW-2:0], 1'b0};
    rem_sub  = rem_sh;
    if (rem_sh >= {1'b0, opb_q}) begin
      rem_sub   = rem_sh - {1'b0, opb_q};
      quo_sh[0] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    dst_d       = dst_q;
    we_d        = we_q;
    div0_d      = div0_flag;
    reg_write_d = 1'b0;
    a3_d        = '0;
    wd3_d       = '0;
    unique case (state_q)
      StIdle: begin
        if (sel[MUL_B] || sel[DIV_B]) begin
          state_d = sel[MUL_B] ? StMulRun : StDivRun;
          cnt_d   = CW'(DW - 1);
          acc_d   = sel[MUL_B] ? '0 : op_a;
          rem_d   = '0;
          opa_d   = op_a;
          opb_d   = op_b;
          dst_d   = r1E_addr;
          we_d    = RegWriteE;
        end else begin
          reg_write_d = RegWriteE;
          a3_d        = r1E_addr;
          wd3_d       = alu_res;
        end
      end
      StMulRun: begin
        acc_d = mul_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d     = StIdle;
          reg_write_d = we_q;
          a3_d        = dst_q;
          wd3_d       = mul_step;
        end
      end
      StDivRun: begin
        acc_d = quo_sh;
        rem_d = rem_sub;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d     = StIdle;
          reg_write_d = we_q;
          a3_d        = dst_q;
          wd3_d       = (opb_q == '0) ? '1 : quo_sh;
          if (opb_q == '0) div0_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge RegRst) begin
    if (RegRst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      RegWriteW <= 1'b0;
      a3W       <= '0;
      wd3       <= '0;
      div0_flag <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      dst_q     <= dst_d;
      we_q      <= we_d;
      RegWriteW <= reg_write_d;
      a3W       <= a3_d;
      wd3       <= wd3_d;
      div0_flag <= div0_d;
    end
  end

endmodule
